// File: rtl/ysyx_22040228_div_pkg.sv
// Shared types and sizing for the iterative restoring divider.
package ysyx_22040228_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    localparam int DIV_XLEN_DEFAULT = 64;
    localparam int DIV_CNT_W        = $clog2(DIV_XLEN_DEFAULT) + 1;

    // Counter must hold the full iteration count XLEN, hence the extra bit.
    function automatic int div_cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/ysyx_22040228_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module ysyx_22040228_div_step
    import ysyx_22040228_div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEFAULT
) (
    input  logic [XLEN:0]   i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic            o_q
);

    logic [XLEN+1:0] w_shift;
    logic [XLEN:0]   w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift[XLEN:0] - {1'b0, i_divisor};
    assign o_q     = (w_shift >= {2'b00, i_divisor});
    assign o_rem   = o_q ? w_diff : w_shift[XLEN:0];

endmodule

// File: rtl/ysyx_22040228_div_param.sv
// Multi-cycle signed/unsigned divider (DIV/DIVU/REM/REMU and *W forms) with valid/ready handshakes.
module ysyx_22040228_div_param
    import ysyx_22040228_div_pkg::*;
#(
    parameter int XLEN     = DIV_XLEN_DEFAULT,
    parameter int WORD_OPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_word,
    input  logic            want_rem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = div_cnt_width(XLEN);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] BIT31 = XLEN'(1) << 31;
    localparam logic [XLEN-1:0] MIN_W = ~(BIT31 - XLEN'(1));

    // Low 32 bits of x extended to XLEN, signed or unsigned.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sx);
        logic [XLEN-1:0] sh;
        sh = x << (XLEN - 32);
        if (sx)
            ext32 = $signed(sh) >>> (XLEN - 32);
        else
            ext32 = sh >> (XLEN - 32);
    endfunction

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN:0]    r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [XLEN-1:0]  r_result;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_word;
    logic             r_want_rem;

    logic             w_word;
    logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_abs, w_b_abs;
    logic             w_a_neg, w_b_neg;
    logic             w_div_zero, w_overflow;
    logic [XLEN-1:0]  w_sp_res, w_sp_out;
    logic [XLEN-1:0]  w_preload;
    logic [CNT_W-1:0] w_iters;
    logic [XLEN:0]    w_step_rem;
    logic             w_step_q;
    logic [XLEN-1:0]  w_fix_q, w_fix_r, w_fix_sel, w_fix_res;

    generate
        if (WORD_OPS != 0 && XLEN == 64) begin : g_word
            assign w_word = is_word;
        end else begin : g_noword
            assign w_word = 1'b0;
        end
    endgenerate

    // Request-side operand conditioning, evaluated only when a request is accepted.
    assign w_a_ext    = w_word ? ext32(dividend, is_signed) : dividend;
    assign w_b_ext    = w_word ? ext32(divisor, is_signed) : divisor;
    assign w_a_neg    = is_signed & w_a_ext[XLEN-1];
    assign w_b_neg    = is_signed & w_b_ext[XLEN-1];
    assign w_a_abs    = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_abs    = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_div_zero = (w_b_ext == '0);
    assign w_overflow = is_signed & (w_a_ext == (w_word ? MIN_W : MIN_X)) & (&w_b_ext);

    assign w_sp_res   = want_rem ? (w_div_zero ? w_a_ext : '0)
                                 : (w_div_zero ? '1 : w_a_ext);
    assign w_sp_out   = w_word ? ext32(w_sp_res, 1'b1) : w_sp_res;

    // Word magnitudes are parked in the top half so the MSB-first shift starts at bit 31.
    assign w_preload  = w_word ? (w_a_abs << (XLEN - 32)) : w_a_abs;
    assign w_iters    = w_word ? CNT_W'(32) : CNT_W'(XLEN);

    ysyx_22040228_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_quo[XLEN-1]),
        .i_divisor(r_div),
        .o_rem    (w_step_rem),
        .o_q      (w_step_q)
    );

    assign w_fix_q   = r_neg_q ? -r_quo : r_quo;
    assign w_fix_r   = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    assign w_fix_sel = r_want_rem ? w_fix_r : w_fix_q;
    assign w_fix_res = r_word ? ext32(w_fix_sel, 1'b1) : w_fix_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_result   <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_word     <= 1'b0;
            r_want_rem <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_word     <= w_word;
                        r_want_rem <= want_rem;
                        r_div      <= w_b_abs;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        if (w_div_zero || w_overflow) begin
                            r_result <= w_sp_out;
                            r_state  <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_preload;
                            r_cnt   <= w_iters;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_step_q};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule

// File: doc/ysyx_22040228_div_param.md
YSYX_22040228_DIV_PARAM -- requirements
Module: ysyx_22040228_div_param

Interface
REQ-001 SHALL provide parameter XLEN, default 64, operand and result width; legal values 32 and 64.
REQ-002 SHALL provide parameter WORD_OPS, default 1, enabling 32-bit word operations; legal only when XLEN=64.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-005 SHALL have port flush, input, 1, abort any operation in flight.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1) forming the request handshake.
REQ-007 SHALL have ports dividend and divisor, input, XLEN each, the operands.
REQ-008 SHALL have port is_signed, input, 1: 1 selects DIV/REM, 0 selects DIVU/REMU.
REQ-009 SHALL have port is_word, input, 1, selecting *W variants; tied to 0 internally when WORD_OPS=0.
REQ-010 SHALL have port want_rem, input, 1: 1 returns the remainder, 0 returns the quotient.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1) forming the response handshake.
REQ-012 SHALL have port result, output, XLEN, the quotient or remainder.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE; in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
REQ-014 SHALL accept a request on the edge where in_valid and in_ready are both 1, and SHALL latch all request inputs on that edge.
REQ-015 SHALL set effective width W=32 when is_word=1, otherwise W=XLEN; word operands are the low 32 bits, sign-extended if is_signed=1, else zero-extended.
REQ-016 SHALL take absolute values of signed operands at acceptance; quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-017 SHALL perform restoring division in CALC, one quotient bit per cycle, for exactly W cycles, using a W+1-bit partial remainder.
REQ-018 SHALL apply sign correction and word sign-extension in FIX (one cycle), then enter DONE.
REQ-019 SHALL give normal latency: out_valid first high W+2 cycles after the acceptance cycle (66 for XLEN=64, 34 for word operations).
REQ-020 SHALL handle divide-by-zero in a special path: quotient all ones, remainder = (extended) dividend.
REQ-021 SHALL handle signed overflow (most-negative dividend / -1) in a special path: quotient = dividend, remainder = 0.
REQ-022 SHALL take special-path requests from IDLE straight to DONE; out_valid is high the cycle after acceptance.
REQ-023 SHALL, for word operations, return bits [31:0] of the result sign-extended to XLEN, for signed and unsigned alike.
REQ-024 SHALL hold result stable in DONE while out_ready=0; on out_valid and out_ready both 1, SHALL return to IDLE next edge.
REQ-025 SHALL, on flush=1, enter IDLE at the next edge from any state and discard the result; flush overrides a same-cycle request or response handshake.
REQ-026 SHALL take the opcode into account only at acceptance; later input changes have no effect.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, force state IDLE, in_ready=1 in the following cycle, out_valid=0, result=0, and all counters and datapath registers to 0.
REQ-028 SHALL give rst priority over flush and over both handshakes, including mid-CALC.

Structure
REQ-029 SHALL place the state enum, the XLEN default and the iteration-counter width ($clog2(XLEN)+1) in a shared package ysyx_22040228_div_pkg.
REQ-030 SHALL implement the single-iteration compare/subtract/shift step as a combinational sub-module ysyx_22040228_div_step, parametrised by XLEN.
REQ-031 SHALL contain no multi-cycle combinational paths; the sequential control lives only in the top module.

Verification
REQ-032 SHALL cover signed DIV/REM, XLEN=64: -7 / 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF, out_valid 66 cycles after acceptance.
REQ-033 SHALL cover DIVU by zero: 5 / 0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REMU returns 5.
REQ-034 SHALL cover signed overflow: 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-035 SHALL cover DIVUW: 0x1234_5678_8000_0000 / 1 -> 0xFFFF_FFFF_8000_0000 after 34 cycles.
REQ-036 SHALL cover back-pressure: out_ready low for 10 cycles in DONE -> result stable and in_ready=0; after the handshake, in_ready=1 the next cycle.
REQ-037 SHALL cover flush at CALC iteration 20 -> IDLE next cycle, no out_valid; the next request, 100 / 7 unsigned, returns 14.
